// File: rtl/ldpc_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_encoder_pkg
// Description : Shared definitions for the LDPC encoder pipeline: default
//               vector width, the dense PHI^-1 matrix constant and the FSM
//               state encoding used by the dense multiply stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_encoder_pkg;

    localparam int DEFAULT_WIDTH          = 96;
    localparam int DEFAULT_BITS_PER_CYCLE = 8;

    // Row i of the matrix lives at index [i]; bit j of a row is column j.
    typedef logic [DEFAULT_WIDTH-1:0][DEFAULT_WIDTH-1:0] matrix_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Dense pseudo-random rows from an LFSR walk, with the diagonal folded in
    // so every row is distinct and non-zero.
    function automatic matrix_t build_phi_inv();
        matrix_t                   m;
        logic [DEFAULT_WIDTH-1:0]  s;
        s = 96'hC3A596E10F1E2D3C4B5A6978;
        for (int i = 0; i < DEFAULT_WIDTH; i++) begin
            for (int j = 0; j < 7; j++) begin
                s = {s[DEFAULT_WIDTH-2:0],
                     s[DEFAULT_WIDTH-1] ^ s[DEFAULT_WIDTH-3] ^ s[DEFAULT_WIDTH-6] ^ s[0]};
            end
            m[i] = s ^ (DEFAULT_WIDTH'(1) << i);
        end
        return m;
    endfunction

    localparam matrix_t PHI_INV = build_phi_inv();

endpackage
`default_nettype wire

// File: rtl/phi_inv_chunk_xor.sv
`default_nettype none
// ============================================================================
// Module      : phi_inv_chunk_xor
// Description : Combinational GF(2) partial product: XOR of the matrix rows
//               whose select bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module phi_inv_chunk_xor #(
    parameter int WIDTH          = 96,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic [BITS_PER_CYCLE-1:0]            sel,
    input  logic [BITS_PER_CYCLE-1:0][WIDTH-1:0] rows,
    output logic [WIDTH-1:0]                     xor_out
);

    // Accumulate every selected row of this chunk.
    always_comb begin
        xor_out = '0;
        for (int b = 0; b < BITS_PER_CYCLE; b++) begin
            if (sel[b]) begin
                xor_out = xor_out ^ rows[b];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dense_mult_by_phi_inv.sv
`default_nettype none
// ============================================================================
// Module      : dense_mult_by_phi_inv
// Description : Multiplies a WIDTH-bit vector by a dense GF(2) matrix,
//               absorbing BITS_PER_CYCLE input bits per compute cycle, with
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module dense_mult_by_phi_inv
    import ldpc_encoder_pkg::*;
#(
    parameter int                            WIDTH          = ldpc_encoder_pkg::DEFAULT_WIDTH,
    parameter int                            BITS_PER_CYCLE = ldpc_encoder_pkg::DEFAULT_BITS_PER_CYCLE,
    parameter logic [WIDTH-1:0][WIDTH-1:0]   MATRIX         = ldpc_encoder_pkg::PHI_INV
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    output logic [WIDTH-1:0] o_output_data,
    output logic             o_output_valid,
    input  logic             i_output_ready
);

    localparam int NUM_CHUNKS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_chunking
        $error("dense_mult_by_phi_inv: WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    state_t                                           r_state;
    state_t                                           w_state_next;
    logic [WIDTH-1:0]                                 r_data;
    logic [WIDTH-1:0]                                 r_acc;
    logic [CNT_W-1:0]                                 r_cnt;
    logic                                             w_in_xfer;
    logic                                             w_out_xfer;
    logic [WIDTH-1:0]                                 w_chunk_xor;
    // Same bit layout as MATRIX / r_data, just regrouped so a chunk can be
    // picked with the counter as a plain index.
    logic [NUM_CHUNKS-1:0][BITS_PER_CYCLE-1:0][WIDTH-1:0] w_matrix_chunks;
    logic [NUM_CHUNKS-1:0][BITS_PER_CYCLE-1:0]            w_data_chunks;

    assign w_matrix_chunks = MATRIX;
    assign w_data_chunks   = r_data;
    assign w_in_xfer       = i_input_valid & o_input_ready;
    assign w_out_xfer      = o_output_valid & i_output_ready;

    phi_inv_chunk_xor #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_chunk_xor (
        .sel     (w_data_chunks[r_cnt]),
        .rows    (w_matrix_chunks[r_cnt]),
        .xor_out (w_chunk_xor)
    );

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next   = r_state;
        o_input_ready  = 1'b0;
        o_output_valid = 1'b0;
        o_output_data  = '0;
        case (r_state)
            ST_IDLE: begin
                o_input_ready = 1'b1;
                if (i_input_valid) begin
                    w_state_next = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (r_cnt == LAST_CHUNK) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_output_valid = 1'b1;
                o_output_data  = r_acc;
                // Accepting a new vector only while the result leaves lets
                // the block run back-to-back without extra buffering.
                o_input_ready  = i_output_ready;
                if (i_output_ready) begin
                    w_state_next = i_input_valid ? ST_COMPUTE : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Input latch, accumulator and chunk counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (w_in_xfer) begin
            r_data <= i_input_data;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_state == ST_COMPUTE) begin
            r_acc <= r_acc ^ w_chunk_xor;
            if (r_cnt != LAST_CHUNK) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dense_mult_by_phi_inv.sv
`default_nettype none
// ============================================================================
// Module      : tb_dense_mult_by_phi_inv
// Description : Self-checking bench for dense_mult_by_phi_inv using three
//               instances (identity, rotate-by-one and PHI_INV matrices).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dense_mult_by_phi_inv;
    import ldpc_encoder_pkg::*;

    localparam int W    = 96;
    localparam int NDUT = 3;
    localparam int LAT  = 12;

    typedef logic [W-1:0] vec_t;

    function automatic matrix_t make_ident();
        matrix_t m;
        for (int i = 0; i < W; i++) m[i] = vec_t'(1) << i;
        return m;
    endfunction

    function automatic matrix_t make_shift();
        matrix_t m;
        for (int i = 0; i < W; i++) m[i] = vec_t'(1) << ((i + 1) % W);
        return m;
    endfunction

    localparam matrix_t M_IDENT = make_ident();
    localparam matrix_t M_SHIFT = make_shift();

    // Golden model: XOR of the rows selected by the set input bits.
    function automatic vec_t gf2_mul(matrix_t m, vec_t v);
        vec_t r = '0;
        for (int i = 0; i < W; i++) if (v[i]) r = r ^ m[i];
        return r;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  [NDUT];
    vec_t din  [NDUT];
    logic iv   [NDUT];
    logic ir   [NDUT];
    vec_t dout [NDUT];
    logic ov   [NDUT];
    logic ordy [NDUT];

    dense_mult_by_phi_inv #(.WIDTH(W), .BITS_PER_CYCLE(8), .MATRIX(M_IDENT)) u_dut_ident (
        .i_clock(clk), .i_reset(rst[0]), .i_input_data(din[0]), .i_input_valid(iv[0]),
        .o_input_ready(ir[0]), .o_output_data(dout[0]), .o_output_valid(ov[0]),
        .i_output_ready(ordy[0]));

    dense_mult_by_phi_inv #(.WIDTH(W), .BITS_PER_CYCLE(8), .MATRIX(M_SHIFT)) u_dut_shift (
        .i_clock(clk), .i_reset(rst[1]), .i_input_data(din[1]), .i_input_valid(iv[1]),
        .o_input_ready(ir[1]), .o_output_data(dout[1]), .o_output_valid(ov[1]),
        .i_output_ready(ordy[1]));

    dense_mult_by_phi_inv #(.WIDTH(W), .BITS_PER_CYCLE(8)) u_dut_phi (
        .i_clock(clk), .i_reset(rst[2]), .i_input_data(din[2]), .i_input_valid(iv[2]),
        .o_input_ready(ir[2]), .o_output_data(dout[2]), .o_output_valid(ov[2]),
        .i_output_ready(ordy[2]));

    int tests  = 0;
    int failed = 0;

    task automatic chk(input string nm, input vec_t act, input vec_t exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a vector and hold it until it is taken (returns just after the
    // transfer edge).
    task automatic send(input int k, input vec_t data, input string nm);
        int n = 0;
        din[k] = data;
        iv[k]  = 1'b1;
        while (!ir[k] && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk_int({nm, "_accept_timeout"}, n, 0);
        tick();
        iv[k] = 1'b0;
    endtask

    // Count cycles until valid, checking ready stays low meanwhile.
    task automatic wait_result(input int k, input vec_t exp, input string nm);
        int   n       = 0;
        logic rdy_bad = 1'b0;
        while (!ov[k] && n < 50) begin
            if (ir[k]) rdy_bad = 1'b1;
            tick();
            n++;
        end
        chk_int({nm, "_latency"}, n, LAT);
        chk({nm, "_ready_low"}, vec_t'(rdy_bad), '0);
        chk({nm, "_data"}, dout[k], exp);
    endtask

    typedef struct {
        int    sel;
        vec_t  din;
        vec_t  exp;
        string nm;
    } vec_rec_t;

    vec_rec_t tbl [12];
    vec_t     q   [$];

    initial begin
        vec_t a, b, e;
        int   sent, recv, gap;
        logic bad;
        bit   xfer;

        // Test vectors: identity and rotate-left-by-one expectations.
        a = 96'h0123456789ABCDEF_DEADBEEF;
        tbl[0]  = '{0, 96'h1,     96'h1,     "ident_one"};
        tbl[1]  = '{0, '1,        '1,        "ident_ones"};
        tbl[2]  = '{0, '0,        '0,        "ident_zero"};
        tbl[3]  = '{0, a,         a,         "ident_pat"};
        tbl[4]  = '{1, vec_t'(1) << 95, 96'h1, "shift_bit95"};
        tbl[5]  = '{1, '0,        '0,        "shift_zero"};
        tbl[6]  = '{1, 96'h1,     96'h2,     "shift_one"};
        tbl[7]  = '{1, (vec_t'(1) << 95) | 96'h1, 96'h3, "shift_wrap"};
        tbl[8]  = '{1, a,         {a[94:0], a[95]}, "shift_pat"};
        tbl[9]  = '{2, '0,        '0,        "phi_zero"};
        tbl[10] = '{2, 96'h1,     PHI_INV[0],  "phi_row0"};
        tbl[11] = '{2, vec_t'(1) << 95, PHI_INV[95], "phi_row95"};

        for (int k = 0; k < NDUT; k++) begin
            rst[k] = 1'b1; din[k] = '0; iv[k] = 1'b0; ordy[k] = 1'b1;
        end
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_ready%0d", k), vec_t'(ir[k]), 96'h1);
            chk($sformatf("reset_valid%0d", k), vec_t'(ov[k]), '0);
            chk($sformatf("reset_data%0d", k), dout[k], '0);
        end

        // Table-driven single vectors, downstream always ready.
        for (int t = 0; t < 12; t++) begin
            send(tbl[t].sel, tbl[t].din, tbl[t].nm);
            wait_result(tbl[t].sel, tbl[t].exp, tbl[t].nm);
            tick();
            chk({tbl[t].nm, "_valid_drop"}, vec_t'(ov[tbl[t].sel]), '0);
        end

        // Output stall for 20 cycles, then simultaneous in/out transfer.
        a = 96'hA5A5_0000_FFFF_1234_5678_9ABC;
        b = 96'h0F0F_F0F0_1111_2222_3333_4444;
        ordy[0] = 1'b0;
        send(0, a, "stall_a");
        wait_result(0, a, "stall_a");
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (!ov[0] || dout[0] !== a || ir[0]) bad = 1'b1;
        end
        chk("stall_stable", vec_t'(bad), '0);
        din[0] = b; iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        chk("b2b_ready_comb", vec_t'(ir[0]), 96'h1);
        tick();
        iv[0] = 1'b0;
        wait_result(0, b, "b2b_b");
        tick();

        // Reset during compute cycle 5: the vector must never appear.
        send(0, 96'hABC, "rst_mid");
        repeat (4) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rst_mid_ready", vec_t'(ir[0]), 96'h1);
        bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (ov[0]) bad = 1'b1;
            tick();
        end
        chk("rst_mid_no_valid", vec_t'(bad), '0);
        send(0, 96'h77, "post_rst");
        wait_result(0, 96'h77, "post_rst");
        tick();

        // 200 random vectors through the PHI_INV instance with random gaps.
        sent = 0; recv = 0; gap = 0;
        for (int cyc = 0; cyc < 20000 && recv < 200; cyc++) begin
            ordy[2] = ($urandom_range(0, 3) != 0);
            if (!iv[2] && sent < 200) begin
                if (gap == 0) begin
                    iv[2]  = 1'b1;
                    din[2] = {$urandom, $urandom, $urandom};
                end else begin
                    gap--;
                end
            end
            #4;
            xfer = iv[2] && ir[2];
            if (xfer) begin
                q.push_back(gf2_mul(PHI_INV, din[2]));
                sent++;
            end
            if (ov[2] && ordy[2]) begin
                if (q.size() == 0) begin
                    chk("rand_extra_output", dout[2], 'x);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("rand_data%0d", recv), dout[2], e);
                end
                recv++;
            end
            tick();
            if (xfer) begin
                iv[2] = 1'b0;
                gap   = $urandom_range(0, 3);
            end
        end
        chk_int("rand_received", recv, 200);
        chk_int("rand_queue_empty", q.size(), 0);
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ov[2]) bad = 1'b1;
            tick();
        end
        chk("rand_no_duplicate", vec_t'(bad), '0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dense_mult_by_phi_inv.md
DENSE_MULT_BY_PHI_INV -- requirements
Module: dense_mult_by_phi_inv

Interface
REQ-001 SHALL have parameter WIDTH, default 96: vector width in bits, equal to the width of the upstream E-multiply output.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 8: input bits absorbed per compute cycle.
REQ-003 SHALL have parameter MATRIX, default ldpc_encoder_pkg::PHI_INV: array of WIDTH rows, each WIDTH bits, GF(2) matrix.
REQ-004 SHALL have port i_clock  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_input_data  input  WIDTH  vector from the upstream sparse E multiplier.
REQ-007 SHALL have port i_input_valid  input  1  i_input_data is valid.
REQ-008 SHALL have port o_input_ready  output  1  block accepts i_input_data this cycle.
REQ-009 SHALL have port o_output_data  output  WIDTH  product vector.
REQ-010 SHALL have port o_output_valid  output  1  o_output_data is valid.
REQ-011 SHALL have port i_output_ready  input  1  downstream accepts o_output_data this cycle.

Function
REQ-012 SHALL compute o_output_data = XOR of MATRIX[i] over every i where input bit i = 1; the result is 0 when the input is all-zero.
REQ-013 SHALL transfer a word on any rising edge where valid and ready are both high, separately on each side.
REQ-014 SHALL implement FSM states ST_IDLE, ST_COMPUTE, ST_DONE.
REQ-015 SHALL, in ST_IDLE, drive o_input_ready=1; on input transfer: latch input, clear accumulator, clear chunk counter, go to ST_COMPUTE.
REQ-016 SHALL, in ST_COMPUTE, drive o_input_ready=0; each cycle XOR rows for input bits [k*BPC+BPC-1 : k*BPC] (chunk k = counter) into the accumulator and increment the counter.
REQ-017 SHALL go to ST_DONE after chunk WIDTH/BPC-1, giving 12 compute cycles at defaults.
REQ-018 SHALL, in ST_DONE, drive o_output_valid=1 and o_output_data=accumulator, and hold both stable until output transfer.
REQ-019 SHALL, in ST_DONE, drive o_input_ready = i_output_ready (combinational).
REQ-020 SHALL, on output transfer without input transfer, go to ST_IDLE.
REQ-021 SHALL, on simultaneous output and input transfer, latch the new input and go directly to ST_COMPUTE (back-to-back).
REQ-022 SHALL have a latency of WIDTH/BPC cycles from the input-transfer edge to o_output_valid high; sustained throughput SHALL be one vector per WIDTH/BPC+1 cycles.
REQ-023 SHALL drive o_output_data=0 and o_output_valid=0 outside ST_DONE.
REQ-024 SHALL ignore i_input_valid while in ST_COMPUTE; no data is lost because ready is low.
REQ-025 SHALL fail elaboration with an error if WIDTH % BITS_PER_CYCLE != 0.
REQ-026 SHALL size the chunk counter $clog2(WIDTH/BPC) bits; it never wraps past WIDTH/BPC-1.

Reset
REQ-027 SHALL, on i_reset=1 at a clock edge, force state ST_IDLE, clear accumulator, counter and latched input.
REQ-028 SHALL hold outputs at reset: o_output_valid=0, o_output_data=0, o_input_ready=1 in the first cycle after reset deasserts.
REQ-029 SHALL abandon any vector in compute or awaiting output on mid-operation reset; the vector is never emitted.

Structure
REQ-030 SHALL place WIDTH default, the PHI_INV constant and the state enum in package ldpc_encoder_pkg, shared with the E-multiply stage.
REQ-031 SHALL use one sub-module, phi_inv_chunk_xor (combinational): BPC select bits plus BPC rows in, XOR of the selected rows out.

Verification
REQ-032 SHALL test: MATRIX=identity, input 96'h1, ready high -> o_output_valid rises 12 cycles after accept, data 96'h1, o_input_ready low for those 12 cycles.
REQ-033 SHALL test: MATRIX row i = 1<<((i+1)%96), input bit 95 only -> output 96'h1; input 96'h0 -> output 96'h0 after the same latency.
REQ-034 SHALL test: i_output_ready low 20 cycles in ST_DONE -> data and valid stable, o_input_ready low; ready then high with new input valid -> both transfer on the same edge, next valid 12 cycles later.
REQ-035 SHALL test: reset asserted in compute cycle 5 -> no output valid ever appears for that vector; o_input_ready=1 in the cycle after reset release.
REQ-036 SHALL test: 200 random vectors, package PHI_INV, random valid/ready gaps -> every output matches the golden GF(2) model, in order, none dropped or duplicated.
